// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse receiver: oversamples the pad lines, decodes 3-byte movement packets,
// and tracks a clamped absolute X position plus the left-button state.
`timescale 1ns/1ps
module ps2_mouse_tracker #(
  parameter int unsigned X_MAX   = 639,
  parameter int unsigned X_RESET = 0,
  parameter int unsigned TIMEOUT = 5000
) (
  input  logic        clock,
  input  logic        reset_,
  input  logic        ps2_clock,
  input  logic        ps2_data,
  output logic [15:0] mouse_x,
  output logic        mouse_pressed_,
  output logic        packet_strobe,
  output logic [7:0]  error_count
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT);
  localparam logic [15:0] X_MAX_V   = 16'(X_MAX);
  localparam logic [15:0] X_RESET_V = 16'(X_RESET);

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  // Overflow forces the extreme delta; the sum is clamped into [0, X_MAX].
  function automatic logic [15:0] apply_dx(input logic [15:0] x, input logic sign,
                                           input logic ovf, input logic [7:0] delta);
    logic signed [16:0] dx;
    logic signed [16:0] sum;
    if (ovf) begin
      dx = sign ? -17'sd256 : 17'sd255;
    end else begin
      dx = {{8{sign}}, sign, delta};
    end
    sum = signed'({1'b0, x}) + dx;
    if (sum < 17'sd0) begin
      return 16'd0;
    end else if (sum > signed'({1'b0, X_MAX_V})) begin
      return X_MAX_V;
    end else begin
      return sum[15:0];
    end
  endfunction

  logic clk_meta_r, clk_sync_r, clk_prev_r;
  logic data_meta_r, data_sync_r;
  logic fall_s, bit_s;

  rx_state_t state_r, state_nxt_s;
  logic [2:0]        bit_cnt_r;
  logic [7:0]        shift_r;
  logic [1:0]        pkt_idx_r;
  logic              left_r, sign_r, ovf_r;
  logic [7:0]        delta_r;
  logic [IDLE_W-1:0] idle_cnt_r;

  logic partial_s, timeout_s;
  logic shift_en_s, parity_err_s, stop_err_s, frame_done_s, header_err_s, err_event_s;
  logic abort_s, packet_done_s;

  // Two-stage synchronisers plus edge register, all idling high.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      clk_prev_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clock;
      clk_sync_r  <= clk_meta_r;
      clk_prev_r  <= clk_sync_r;
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
    end
  end

  assign fall_s    = clk_prev_r & ~clk_sync_r;
  assign bit_s     = data_sync_r;
  assign partial_s = (state_r != RX_IDLE) || (pkt_idx_r != 2'd0);
  assign timeout_s = ~fall_s & partial_s & (idle_cnt_r == IDLE_LIMIT);

  // Frame receiver state register.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_r <= RX_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Frame receiver next state; an edge always wins over a coincident timeout.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RX_IDLE: begin
        if (fall_s && !bit_s) state_nxt_s = RX_DATA;
        else                  state_nxt_s = RX_IDLE;
      end
      RX_DATA: begin
        if (fall_s)         state_nxt_s = (bit_cnt_r == 3'd7) ? RX_PARITY : RX_DATA;
        else if (timeout_s) state_nxt_s = RX_IDLE;
        else                state_nxt_s = RX_DATA;
      end
      RX_PARITY: begin
        if (fall_s)         state_nxt_s = odd_parity_ok(shift_r, bit_s) ? RX_STOP : RX_IDLE;
        else if (timeout_s) state_nxt_s = RX_IDLE;
        else                state_nxt_s = RX_PARITY;
      end
      RX_STOP: begin
        if (fall_s || timeout_s) state_nxt_s = RX_IDLE;
        else                     state_nxt_s = RX_STOP;
      end
      default: state_nxt_s = RX_IDLE;
    endcase
  end

  // Frame receiver event decode.
  always_comb begin
    shift_en_s   = 1'b0;
    parity_err_s = 1'b0;
    stop_err_s   = 1'b0;
    frame_done_s = 1'b0;
    case (state_r)
      RX_DATA:   shift_en_s   = fall_s;
      RX_PARITY: parity_err_s = fall_s & ~odd_parity_ok(shift_r, bit_s);
      RX_STOP: begin
        frame_done_s = fall_s & bit_s;
        stop_err_s   = fall_s & ~bit_s;
      end
      default: shift_en_s = 1'b0;
    endcase
  end

  assign header_err_s  = frame_done_s & (pkt_idx_r == 2'd0) & ~shift_r[3];
  assign packet_done_s = frame_done_s & (pkt_idx_r == 2'd2);
  assign abort_s       = parity_err_s | stop_err_s | timeout_s;
  assign err_event_s   = abort_s | header_err_s;

  // Serial shifter (LSB first) and data-bit counter.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'd0;
    end else if (shift_en_s) begin
      bit_cnt_r <= bit_cnt_r + 3'd1;
      shift_r   <= {bit_s, shift_r[7:1]};
    end else if (state_r == RX_IDLE) begin
      bit_cnt_r <= 3'd0;
    end
  end

  // Idle counter: cleared by every edge, counts only while something is partial.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      idle_cnt_r <= '0;
    end else if (fall_s || timeout_s) begin
      idle_cnt_r <= '0;
    end else if (partial_s && (idle_cnt_r != IDLE_LIMIT)) begin
      idle_cnt_r <= idle_cnt_r + 1'b1;
    end
  end

  // Packet assembly; a header without bit3 set keeps the index at 0 to resync.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      pkt_idx_r <= 2'd0;
      left_r    <= 1'b0;
      sign_r    <= 1'b0;
      ovf_r     <= 1'b0;
      delta_r   <= 8'd0;
    end else if (abort_s) begin
      pkt_idx_r <= 2'd0;
    end else if (frame_done_s) begin
      case (pkt_idx_r)
        2'd0: begin
          if (shift_r[3]) begin
            left_r    <= shift_r[0];
            sign_r    <= shift_r[4];
            ovf_r     <= shift_r[6];
            pkt_idx_r <= 2'd1;
          end
        end
        2'd1: begin
          delta_r   <= shift_r;
          pkt_idx_r <= 2'd2;
        end
        default: pkt_idx_r <= 2'd0;
      endcase
    end
  end

  // Registered outputs.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      mouse_x        <= X_RESET_V;
      mouse_pressed_ <= 1'b1;
      packet_strobe  <= 1'b0;
      error_count    <= 8'd0;
    end else begin
      packet_strobe <= packet_done_s;
      if (packet_done_s) begin
        mouse_x        <= apply_dx(mouse_x, sign_r, ovf_r, delta_r);
        mouse_pressed_ <= ~left_r;
      end
      if (err_event_s && (error_count != 8'hFF)) begin
        error_count <= error_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Self-checking bench for ps2_mouse_tracker: directed scenarios plus randomized
// frame streams checked against a packet-level behavioural model.
`timescale 1ns/1ps
module tb_ps2_mouse_tracker;
  localparam int X_MAX   = 639;
  localparam int TIMEOUT = 5000;
  localparam int HALF    = 4;

  logic        clock = 1'b0;
  logic        reset_ = 1'b0;
  logic        ps2_clock = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] mouse_x;
  logic        mouse_pressed_;
  logic        packet_strobe;
  logic [7:0]  error_count;

  int n_checks = 0;
  int n_fail = 0;
  int strobe_seen = 0;

  int m_x, m_pressed, m_err, m_idx, m_strobes;
  logic [7:0] m_b0, m_b1;

  ps2_mouse_tracker #(.X_MAX(X_MAX), .X_RESET(0), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_(reset_), .ps2_clock(ps2_clock), .ps2_data(ps2_data),
    .mouse_x(mouse_x), .mouse_pressed_(mouse_pressed_),
    .packet_strobe(packet_strobe), .error_count(error_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (packet_strobe) strobe_seen <= strobe_seen + 1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic model_reset();
    m_x = 0; m_pressed = 1; m_err = 0; m_idx = 0;
  endtask

  task automatic model_error();
    if (m_err < 255) m_err++;
    m_idx = 0;
  endtask

  // Packet-level view of what one received frame does to the tracker.
  task automatic model_frame(input logic [7:0] b, input bit ok);
    int dx;
    if (!ok) begin
      model_error();
    end else if (m_idx == 0) begin
      if (b[3]) begin m_b0 = b; m_idx = 1; end
      else model_error();
    end else if (m_idx == 1) begin
      m_b1 = b; m_idx = 2;
    end else begin
      if (m_b0[6]) dx = m_b0[4] ? -256 : 255;
      else         dx = m_b0[4] ? int'(m_b1) - 256 : int'(m_b1);
      m_x = m_x + dx;
      if (m_x < 0) m_x = 0;
      if (m_x > X_MAX) m_x = X_MAX;
      m_pressed = m_b0[0] ? 0 : 1;
      m_strobes++;
      m_idx = 0;
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clock) ps2_data = b;
    wait_cycles(HALF);
    ps2_clock = 1'b0;
    wait_cycles(HALF);
    ps2_clock = 1'b1;
  endtask

  // kind: 0 = good frame, 1 = wrong parity, 2 = stop bit 0
  task automatic send_frame(input logic [7:0] b, input int kind);
    logic par;
    par = ~^b;
    if (kind == 1) par = ~par;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(par);
    drive_bit((kind == 2) ? 1'b0 : 1'b1);
    ps2_data = 1'b1;
    wait_cycles(6);
    model_frame(b, kind == 0);
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, "_x"}, int'(mouse_x), m_x);
    check_eq({tag, "_btn"}, int'(mouse_pressed_), m_pressed);
    check_eq({tag, "_err"}, int'(error_count), m_err);
    check_eq({tag, "_strobes"}, strobe_seen, m_strobes);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input string tag);
    send_frame(b0, 0);
    send_frame(b1, 0);
    send_frame(b2, 0);
    check_model(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovf_exp[3];
    int kind;
    logic [7:0] b;
    ovf_exp = '{255, 510, 639};
    model_reset();
    m_strobes = 0;

    wait_cycles(3);
    check_eq("rst_x", int'(mouse_x), 0);
    check_eq("rst_btn", int'(mouse_pressed_), 1);
    check_eq("rst_strobe", int'(packet_strobe), 0);
    check_eq("rst_err", int'(error_count), 0);
    reset_ = 1'b1;
    wait_cycles(5);

    send_packet(8'h09, 8'h0A, 8'h00, "move1");
    check_eq("move1_x_const", int'(mouse_x), 10);
    check_eq("move1_btn_const", int'(mouse_pressed_), 0);
    check_eq("move1_pulses", strobe_seen, 1);
    send_packet(8'h18, 8'hFB, 8'h00, "move2");
    check_eq("move2_x_const", int'(mouse_x), 5);
    check_eq("move2_btn_const", int'(mouse_pressed_), 1);
    send_packet(8'h18, 8'hF0, 8'h00, "clamp_lo");
    check_eq("clamp_lo_const", int'(mouse_x), 0);
    for (int k = 0; k < 3; k++) begin
      send_packet(8'h48, 8'h00, 8'h00, "ovf");
      check_eq("ovf_const", int'(mouse_x), ovf_exp[k]);
    end

    send_frame(8'h08, 1);
    check_model("parity");
    check_eq("parity_err_const", int'(error_count), 1);
    send_packet(8'h18, 8'hF6, 8'h00, "after_parity");
    check_eq("after_parity_const", int'(mouse_x), 629);

    send_frame(8'h00, 0);
    check_eq("resync_err_const", int'(error_count), 2);
    send_packet(8'h08, 8'h03, 8'h00, "resync");
    check_eq("resync_x_const", int'(mouse_x), 632);

    send_frame(8'h09, 2);
    check_model("stop_err");

    send_frame(8'h08, 0);
    wait_cycles(TIMEOUT - 50);
    check_eq("timeout_early", int'(error_count), m_err);
    wait_cycles(100);
    model_error();
    check_eq("timeout_err", int'(error_count), m_err);
    send_packet(8'h08, 8'h05, 8'h00, "after_timeout");
    check_eq("after_timeout_const", int'(mouse_x), 637);
    wait_cycles(TIMEOUT + 100);
    check_eq("idle_no_timeout", int'(error_count), m_err);

    // Reset in the middle of a frame, checked before any clock edge.
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    @(negedge clock);
    #2 reset_ = 1'b0;
    #1;
    check_eq("midrst_x", int'(mouse_x), 0);
    check_eq("midrst_btn", int'(mouse_pressed_), 1);
    check_eq("midrst_err", int'(error_count), 0);
    model_reset();
    wait_cycles(3);
    reset_ = 1'b1;
    wait_cycles(5);
    send_packet(8'h09, 8'h07, 8'h00, "after_rst");

    for (int p = 0; p < 40; p++) begin
      for (int f = 0; f < 3; f++) begin
        b = 8'($urandom);
        if (f == 0) b[3] = ($urandom_range(0, 7) != 0);
        kind = $urandom_range(0, 9);
        if (kind > 2) kind = 0;
        send_frame(b, kind);
        check_model("rand");
      end
    end
    wait_cycles(TIMEOUT + 100);
    if (m_idx != 0) model_error();
    check_model("rand_end");

    for (int i = 0; i < 300; i++) send_frame(8'hA5, 1);
    check_eq("sat_err", int'(error_count), 255);
    check_model("sat");
    send_packet(8'h08, 8'h02, 8'h00, "after_sat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_mouse_tracker.md
# ps2_mouse_tracker

Receives the PS/2 mouse serial stream, decodes standard 3-byte movement packets, and maintains an absolute, clamped horizontal position and a left-button state. It is the producer side of the `mouse_x` / `mouse_pressed_` interface consumed by the counter/UI logic. It runs entirely in the system clock domain and oversamples the PS/2 clock and data lines.

## Interface
- `X_MAX`, 639: upper clamp for `mouse_x`, inclusive.
- `X_RESET`, 0: value of `mouse_x` after reset; must be ≤ `X_MAX`.
- `TIMEOUT`, 5000: idle system cycles before a partial frame or partial packet is aborted.
- `clock` in 1: system clock; all logic is on its rising edge.
- `reset_` in 1: asynchronous, active-low reset.
- `ps2_clock` in 1: raw PS/2 clock from the pad; asynchronous; idles high.
- `ps2_data` in 1: raw PS/2 data from the pad; asynchronous; idles high.
- `mouse_x` out 16: absolute X position, always in 0..`X_MAX`.
- `mouse_pressed_` out 1: left button state, active-low (0 = pressed).
- `packet_strobe` out 1: one-cycle pulse when a valid packet has updated the outputs.
- `error_count` out 8: count of rejected frames and packets; saturates at 255.

## Operation
- **Synchronisation**
  - `ps2_clock` and `ps2_data` each pass through a 2-flop synchroniser; the flops reset to 1.
  - A falling edge is detected when the previous synced clock is 1 and the current one is 0.
  - The synced data is sampled on that same cycle.
- **Frame format:** 11 bits, in order:
  - start bit, must be 0;
  - 8 data bits, LSB first;
  - odd parity bit;
  - stop bit, must be 1.
- **Frame receiver states:** IDLE → DATA(8 bits) → PARITY → STOP → IDLE.
  - IDLE: a sampled 0 enters DATA. A sampled 1 is ignored and is not counted as an error.
  - Parity error: frame discarded, packet index returns to 0, `error_count`+1.
  - Stop bit 0: frame discarded, packet index returns to 0, `error_count`+1.
- **Packet assembly:** the packet index runs 0, 1, 2.
  - Byte 0 flags: bit0 = left button, bit3 = always 1, bit4 = X sign, bit6 = X overflow.
  - Byte 0 with bit3 = 0 is discarded, the index stays 0, `error_count`+1. This is how the decoder resynchronises.
  - Byte 1 is the X delta, low 8 bits.
  - Byte 2 is the Y delta; it is received and ignored.
- **Update, on acceptance of byte 2:**
  - dx = 9-bit signed {sign, byte1}, sign-extended.
  - If the overflow bit is set, dx = −256 when sign = 1, else +255.
  - The sum `mouse_x` + dx is computed in 17-bit signed and clamped to [0, `X_MAX`].
  - `mouse_pressed_` ← ~bit0.
- **Timeout:** an idle counter resets on every detected falling edge.
  - When it reaches `TIMEOUT` while a frame or packet is partial (receiver ≠ IDLE or packet index ≠ 0), the frame and packet are aborted and `error_count`+1, once per abort.
  - With no partial state, the counter holds and nothing happens.
- **Simultaneous events:** a timeout and a falling edge in the same cycle resolve in favour of the edge; no abort occurs.
- **`error_count`:** an increment at 255 leaves it at 255.

## Timing
- Reset values:
  - `mouse_x` = `X_RESET`;
  - `mouse_pressed_` = 1;
  - `packet_strobe` = 0;
  - `error_count` = 0;
  - receiver IDLE, packet index 0, idle counter 0.
- Reset asserted mid-frame or mid-packet discards everything at once. After release, reception restarts at IDLE, and a frame already in flight is rejected naturally (it fails the start, parity or stop check, or hits the timeout).
- Pad to sample latency: a `ps2_clock` falling transition is sampled 3 clock edges later, comprising 2 synchroniser stages plus the edge register.
- Output update: `mouse_x`, `mouse_pressed_` and `packet_strobe` = 1 all change on the clock edge after the cycle in which byte 2's stop bit is sampled. `packet_strobe` returns to 0 on the next edge.
- `error_count` changes on the clock edge after the cycle in which the offending bit is sampled or the timeout is reached.
- Outputs hold their values between packets. There is no ready/valid back-pressure; the consumer samples levels.

## Test plan
- **Reset:** assert `reset_` = 0 asynchronously mid-stream → `mouse_x` = 0, `mouse_pressed_` = 1, `error_count` = 0 immediately, without a clock edge.
- **Normal move:** packet 0x09, 0x0A, 0x00 → `mouse_x` 0→10, `mouse_pressed_` = 0, one `packet_strobe` pulse; then 0x18, 0xFB, 0x00 → `mouse_x` = 5, `mouse_pressed_` = 1.
- **Clamp:** from `mouse_x` = 5, packet 0x18, 0xF0, 0x00 (dx = −16) → `mouse_x` = 0. Overflow packet 0x48, 0x00, 0x00 repeated 3 times → 255, 510, 639.
- **Parity error:** byte 0 sent with even parity → no strobe, `error_count` = 1, outputs unchanged. The next valid packet is accepted.
- **Resync:** stream 0x00, then a valid 0x08, 0x03, 0x00 → first byte rejected (`error_count` +1), then `mouse_x` increases by 3.
- **Timeout:** send byte 0 only, then idle for `TIMEOUT` cycles → `error_count` +1, index reset. A following full packet is decoded correctly. With 300 consecutive bad frames, `error_count` stays at 255.
